eth_idma_reg_frontend: RTL and testbench

ETH_IDMA_REG_FRONTEND -- requirements
Module: eth_idma_reg_frontend

---
 rtl/eth_idma_reg_frontend.sv | 206 ++++++++++++++++++++
 tb/tb_eth_idma_reg_frontend.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_idma_reg_frontend.sv
// Register-bus target that configures the station MAC and launches single iDMA transfers.
// Each request gets one registered ack; CTRL reports busy/done/error of the transfer engine.
module eth_idma_reg_frontend #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic [47:0]            mac_addr_o,
  output logic [DataWidth-1:0]   idma_src_addr_o,
  output logic [DataWidth-1:0]   idma_dst_addr_o,
  output logic [DataWidth-1:0]   idma_length_o,
  output logic                   idma_req_valid_o,
  input  logic                   idma_req_ready_i,
  input  logic                   idma_rsp_valid_i,
  input  logic                   idma_rsp_error_i,
  output logic                   idma_rsp_ready_o
);

  localparam int StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DataWidth-1:0] r_mac_lo;
  logic [15:0]          r_mac_hi;
  logic [DataWidth-1:0] r_src;
  logic [DataWidth-1:0] r_dst;
  logic [DataWidth-1:0] r_len;
  logic                 r_done;
  logic                 r_error;
  logic                 r_ready;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_rerr;
  // Set once the current held request is acked; cleared when valid drops.
  // Comes out of reset set so a request held across reset release is never acked.
  logic                 r_served;

  logic w_accept;
  logic w_busy;
  logic w_sel_mac_lo;
  logic w_sel_mac_hi;
  logic w_sel_src;
  logic w_sel_dst;
  logic w_sel_len;
  logic w_sel_ctrl;
  logic w_mapped;
  logic w_launch_bit;
  logic w_clear_bit;
  logic w_err;
  logic w_wr_ok;
  logic w_launch;
  logic w_clear;
  logic w_complete;
  logic [DataWidth-1:0] w_cur;
  logic [DataWidth-1:0] w_rdata;
  logic [DataWidth-1:0] w_merged;

  assign w_busy       = (r_state != S_IDLE);
  assign w_accept     = reg_valid_i && !r_ready && !r_served;

  assign w_sel_mac_lo = (reg_addr_i == AddrWidth'(8'h00));
  assign w_sel_mac_hi = (reg_addr_i == AddrWidth'(8'h04));
  assign w_sel_src    = (reg_addr_i == AddrWidth'(8'h10));
  assign w_sel_dst    = (reg_addr_i == AddrWidth'(8'h14));
  assign w_sel_len    = (reg_addr_i == AddrWidth'(8'h18));
  assign w_sel_ctrl   = (reg_addr_i == AddrWidth'(8'h1C));
  assign w_mapped     = w_sel_mac_lo || w_sel_mac_hi || w_sel_src ||
                        w_sel_dst || w_sel_len || w_sel_ctrl;

  assign w_launch_bit = reg_wstrb_i[0] && reg_wdata_i[0];
  assign w_clear_bit  = reg_wstrb_i[0] && reg_wdata_i[1];

  // A CTRL write carrying a launch while busy is rejected as a whole.
  assign w_err = !w_mapped ||
                 (reg_write_i && w_busy &&
                  (w_sel_src || w_sel_dst || w_sel_len || (w_sel_ctrl && w_launch_bit)));

  assign w_wr_ok    = w_accept && reg_write_i && !w_err;
  assign w_launch   = w_wr_ok && w_sel_ctrl && w_launch_bit;
  assign w_clear    = w_wr_ok && w_sel_ctrl && w_clear_bit;
  assign w_complete = (r_state == S_WAIT_RSP) && idma_rsp_valid_i;

  always_comb begin
    w_cur = '0;
    if (w_sel_mac_lo) w_cur = r_mac_lo;
    if (w_sel_mac_hi) w_cur[15:0] = r_mac_hi;
    if (w_sel_src)    w_cur = r_src;
    if (w_sel_dst)    w_cur = r_dst;
    if (w_sel_len)    w_cur = r_len;
  end

  always_comb begin
    w_rdata = w_cur;
    if (w_sel_ctrl) w_rdata[2:0] = {r_error, r_done, w_busy};
  end

  generate
    for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_lane
      assign w_merged[gi*8 +: 8] = reg_wstrb_i[gi] ? reg_wdata_i[gi*8 +: 8] : w_cur[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_launch && (r_len != '0)) w_state_next = S_REQ;
      S_REQ:      if (idma_req_ready_i) w_state_next = S_WAIT_RSP;
      S_WAIT_RSP: if (idma_rsp_valid_i) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
      r_served <= 1'b1;
    end else begin
      r_ready <= w_accept;
      if (w_accept) begin
        r_rerr  <= w_err;
        r_rdata <= (w_err || reg_write_i) ? '0 : w_rdata;
      end else begin
        r_rerr  <= 1'b0;
        r_rdata <= '0;
      end
      if (!reg_valid_i) begin
        r_served <= 1'b0;
      end else if (w_accept) begin
        r_served <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mac_lo <= '0;
      r_mac_hi <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
    end else if (w_wr_ok) begin
      if (w_sel_mac_lo) r_mac_lo <= w_merged;
      if (w_sel_mac_hi) r_mac_hi <= w_merged[15:0];
      if (w_sel_src)    r_src    <= w_merged;
      if (w_sel_dst)    r_dst    <= w_merged;
      if (w_sel_len)    r_len    <= w_merged;
    end
  end

  // Later assignments win: completion overrides a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_clear) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end
      if (w_launch) begin
        r_done  <= (r_len == '0);
        r_error <= (r_len == '0);
      end
      if (w_complete) begin
        r_done <= 1'b1;
        if (idma_rsp_error_i) r_error <= 1'b1;
      end
    end
  end

  assign reg_ready_o      = r_ready;
  assign reg_rdata_o      = r_rdata;
  assign reg_error_o      = r_rerr;
  assign mac_addr_o       = {r_mac_hi, r_mac_lo[31:0]};
  assign idma_src_addr_o  = r_src;
  assign idma_dst_addr_o  = r_dst;
  assign idma_length_o    = r_len;
  assign idma_req_valid_o = (r_state == S_REQ);
  assign idma_rsp_ready_o = (r_state == S_WAIT_RSP);

endmodule

// File: tb/tb_eth_idma_reg_frontend.sv
// Directed bench for eth_idma_reg_frontend: register map, transfer handshake, busy rules and reset.
module tb_eth_idma_reg_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        reg_valid_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [7:0]  reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [3:0]  reg_wstrb_i = '0;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic [47:0] mac_addr_o;
  logic [31:0] idma_src_addr_o;
  logic [31:0] idma_dst_addr_o;
  logic [31:0] idma_length_o;
  logic        idma_req_valid_o;
  logic        idma_req_ready_i = 1'b0;
  logic        idma_rsp_valid_i = 1'b0;
  logic        idma_rsp_error_i = 1'b0;
  logic        idma_rsp_ready_o;

  int n_checks = 0;
  int n_errors = 0;
  int req_cycles = 0;

  eth_idma_reg_frontend #(.AddrWidth(8), .DataWidth(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .reg_valid_i      (reg_valid_i),
    .reg_write_i      (reg_write_i),
    .reg_addr_i       (reg_addr_i),
    .reg_wdata_i      (reg_wdata_i),
    .reg_wstrb_i      (reg_wstrb_i),
    .reg_ready_o      (reg_ready_o),
    .reg_rdata_o      (reg_rdata_o),
    .reg_error_o      (reg_error_o),
    .mac_addr_o       (mac_addr_o),
    .idma_src_addr_o  (idma_src_addr_o),
    .idma_dst_addr_o  (idma_dst_addr_o),
    .idma_length_o    (idma_length_o),
    .idma_req_valid_o (idma_req_valid_o),
    .idma_req_ready_i (idma_req_ready_i),
    .idma_rsp_valid_i (idma_rsp_valid_i),
    .idma_rsp_error_i (idma_rsp_error_i),
    .idma_rsp_ready_o (idma_rsp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (idma_req_valid_o) req_cycles <= req_cycles + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One bus transaction; valid is dropped for a full cycle afterwards.
  task automatic bus_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = strb;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!reg_ready_o && n < 20);
    if (!reg_ready_o) check_val("ack_timeout", 64'(reg_ready_o), 64'd1);
    rdata = reg_rdata_o;
    err   = reg_error_o;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd_v;
    logic        e;
    bus_xfer(1'b1, addr, data, strb, rd_v, e);
    check_val({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    logic [31:0] rd_v;
    logic        e;
    bus_xfer(1'b0, addr, 32'h0, 4'h0, rd_v, e);
    check_val({tag, "_data"}, 64'(rd_v), 64'(exp_data));
    check_val({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  initial begin
    int acks;
    int snap;

    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_ready", 64'(reg_ready_o), 64'd0);
    check_val("rst_rdata", 64'(reg_rdata_o), 64'd0);
    check_val("rst_mac", 64'(mac_addr_o), 64'd0);
    check_val("rst_req_valid", 64'(idma_req_valid_o), 64'd0);
    check_val("rst_rsp_ready", 64'(idma_rsp_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // MAC programming
    wr("mac_lo", 8'h00, 32'h98001032, 4'hF, 1'b0);
    wr("mac_hi", 8'h04, 32'h00002070, 4'hF, 1'b0);
    check_val("mac_addr", 64'(mac_addr_o), 64'h207098001032);
    rd("rd_mac_hi", 8'h04, 32'h00002070, 1'b0);
    rd("rd_misaligned", 8'h01, 32'h0, 1'b1);
    wr("wr_unmapped", 8'h20, 32'h12345678, 4'hF, 1'b1);
    check_val("mac_after_bad", 64'(mac_addr_o), 64'h207098001032);

    // Transfer with back-pressure
    wr("src", 8'h10, 32'h0, 4'hF, 1'b0);
    wr("dst", 8'h14, 32'h1000, 4'hF, 1'b0);
    wr("len", 8'h18, 32'h8, 4'hF, 1'b0);
    wr("launch", 8'h1C, 32'h1, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_val("bp_valid", 64'(idma_req_valid_o), 64'd1);
      check_val("bp_src", 64'(idma_src_addr_o), 64'h0);
      check_val("bp_dst", 64'(idma_dst_addr_o), 64'h1000);
      check_val("bp_len", 64'(idma_length_o), 64'h8);
      @(posedge clk_i);
      #1;
    end
    idma_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    idma_req_ready_i = 1'b0;
    check_val("wait_rsp_ready", 64'(idma_rsp_ready_o), 64'd1);
    check_val("wait_req_valid", 64'(idma_req_valid_o), 64'd0);
    idma_rsp_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    idma_rsp_valid_i = 1'b0;
    check_val("idle_rsp_ready", 64'(idma_rsp_ready_o), 64'd0);
    rd("ctrl_done", 8'h1C, 32'h2, 1'b0);

    // Busy protection
    wr("launch2", 8'h1C, 32'h1, 4'hF, 1'b0);
    wr("busy_src", 8'h10, 32'hDEAD, 4'hF, 1'b1);
    wr("busy_launch", 8'h1C, 32'h1, 4'hF, 1'b1);
    rd("busy_rd_src", 8'h10, 32'h0, 1'b0);
    rd("rd_unmapped", 8'h08, 32'h0, 1'b1);
    rd("ctrl_busy", 8'h1C, 32'h1, 1'b0);
    wr("busy_mac_lo", 8'h00, 32'h98001032, 4'hF, 1'b0);

    // Completion coinciding with a clear: completion wins
    idma_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    idma_req_ready_i = 1'b0;
    idma_rsp_valid_i = 1'b1;
    idma_rsp_error_i = 1'b1;
    wr("clear_vs_done", 8'h1C, 32'h2, 4'hF, 1'b0);
    idma_rsp_valid_i = 1'b0;
    idma_rsp_error_i = 1'b0;
    rd("ctrl_rsp_err", 8'h1C, 32'h6, 1'b0);

    // Zero-length launch
    wr("len0", 8'h18, 32'h0, 4'hF, 1'b0);
    wr("clear0", 8'h1C, 32'h2, 4'hF, 1'b0);
    snap = req_cycles;
    wr("launch_len0", 8'h1C, 32'h1, 4'hF, 1'b0);
    rd("ctrl_len0", 8'h1C, 32'h6, 1'b0);
    check_val("len0_no_req", 64'(req_cycles - snap), 64'd0);
    wr("clear_len0", 8'h1C, 32'h2, 4'hF, 1'b0);
    rd("ctrl_cleared", 8'h1C, 32'h0, 1'b0);

    // Byte strobes and held valid
    wr("len_strb", 8'h18, 32'hFFFFFFFF, 4'h3, 1'b0);
    rd("rd_len_strb", 8'h18, 32'h0000FFFF, 1'b0);
    acks = 0;
    reg_valid_i = 1'b1;
    reg_write_i = 1'b0;
    reg_addr_i  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      if (reg_ready_o) acks++;
    end
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    if (reg_ready_o) acks++;
    check_val("held_one_ack", 64'(acks), 64'd1);

    // Asynchronous reset while waiting for the response
    wr("launch3", 8'h1C, 32'h1, 4'hF, 1'b0);
    idma_req_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    idma_req_ready_i = 1'b0;
    check_val("pre_rst_rsp_ready", 64'(idma_rsp_ready_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    reg_valid_i = 1'b1;
    reg_write_i = 1'b0;
    reg_addr_i  = 8'h1C;
    #1;
    check_val("arst_rsp_ready", 64'(idma_rsp_ready_o), 64'd0);
    check_val("arst_req_valid", 64'(idma_req_valid_o), 64'd0);
    check_val("arst_mac", 64'(mac_addr_o), 64'd0);
    check_val("arst_len", 64'(idma_length_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      if (reg_ready_o) acks++;
    end
    check_val("no_ack_across_rst", 64'(acks), 64'd0);
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rd("ctrl_after_rst", 8'h1C, 32'h0, 1'b0);
    rd("mac_lo_after_rst", 8'h00, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
